// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Parametrised Mealy serial sequence detector. Matches a LEN-bit
//            PATTERN on serial input w using a KMP-style automaton. On a
//            mismatch the detector falls back to the longest pattern prefix
//            that is still live, instead of going back to idle. Adds a sample
//            enable and a saturating match counter with synchronous clear.
// Ports    : Clock   - rising-edge clock
//            Resetn  - asynchronous active-low reset
//            En      - sample enable (w is consumed only when En=1)
//            w       - serial data bit
//            Clear   - synchronous clear of count (FSM unaffected)
//            z       - Mealy match flag (combinational)
//            count   - saturating match count, CNT_W bits
//            state   - matched-prefix length, for debug
//            z_q     - z registered (only with SEQ_DET_REG_OUT_EN)
// Options  : `define SEQ_DET_REG_OUT_EN adds the registered match output z_q.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
  parameter int              LEN     = 4,
  parameter logic [LEN-1:0]  PATTERN = 4'b1101,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic                                Clock,
  input  logic                                Resetn,
  input  logic                                En,
  input  logic                                w,
  input  logic                                Clear,
  output logic                                z,
  output logic [CNT_W-1:0]                    count,
`ifdef SEQ_DET_REG_OUT_EN
  output logic                                z_q,
`endif
  output logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] state
);

  localparam int SW = (LEN > 1) ? $clog2(LEN) : 1;
  // All 2^SW state codes get a table entry; codes >= LEN map to 0.
  localparam int NS = 1 << SW;

  localparam logic [SW-1:0]    LAST_S  = SW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Next-state table, entry index = {S, w}. Built once at elaboration.
  // For matched prefix of length s followed by bit b, the candidate string is
  // P = PATTERN[LEN-1 -: s] , b. The next state is the longest k such that the
  // first k pattern bits equal the last k bits of P. k is capped at LEN-1,
  // which makes a full match fall back to the longest proper border of the
  // pattern (overlapping behaviour); non-overlapping mode forces 0 instead.
  function automatic logic [2*NS*SW-1:0] build_tbl();
    logic [2*NS*SW-1:0] t;
    logic [16:0]        p;
    int                 best;
    logic               ok;
    t = '0;
    for (int s = 0; s < LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        p = '0;
        for (int i = 0; i < LEN; i++) begin
          if (i < s)
            p[i] = PATTERN[LEN-1-i];
          else if (i == s)
            p[i] = b[0];
        end
        best = 0;
        for (int k = 1; k < LEN; k++) begin
          if (k <= s + 1) begin
            ok = 1'b1;
            for (int i = 0; i < LEN; i++) begin
              if (i < k) begin
                if (PATTERN[LEN-1-i] != p[s+1-k+i])
                  ok = 1'b0;
              end
            end
            if (ok)
              best = k;
          end
        end
        if ((s == LEN - 1) && (b[0] == PATTERN[0]) && !OVERLAP)
          best = 0;
        t[(s*2+b)*SW +: SW] = SW'(best);
      end
    end
    return t;
  endfunction

  localparam logic [2*NS*SW-1:0] NXT_TBL = build_tbl();

  logic [SW-1:0]    state_q;
  logic [SW-1:0]    state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [SW:0]      tbl_idx;

  assign tbl_idx = {state_q, w};

  // Gated by Resetn so z is low for the whole reset interval.
  assign z = Resetn & En & (state_q == LAST_S) & (w == PATTERN[0]);

  always_comb begin
    state_d = state_q;
    if (En)
      state_d = NXT_TBL[tbl_idx*SW +: SW];
  end

  always_comb begin
    count_d = count_q;
    if (Clear)
      count_d = '0;
    else if (z && (count_q != CNT_MAX))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign count = count_q;

`ifdef SEQ_DET_REG_OUT_EN
  logic zreg_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      zreg_q <= 1'b0;
    else
      zreg_q <= z;
  end

  assign z_q = zreg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Directed self-checking bench for seq_detector_param. Three
//            instances share one stimulus stream: default parameters,
//            OVERLAP=0, and CNT_W=2 for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

  logic Clock;
  logic Resetn;
  logic En;
  logic w;
  logic Clear;

  logic       z_d,  z_n,  z_s;
  logic [7:0] cnt_d, cnt_n;
  logic [1:0] cnt_s;
  logic [1:0] st_d, st_n, st_s;
`ifdef SEQ_DET_REG_OUT_EN
  logic       zq_d, zq_n, zq_s;
`endif

  int n_vec;
  int n_err;

  // Expected values for the 13-bit saturation stream 1101101101101.
  logic [12:0] sat_w = 13'b1101101101101;
  int ezd_a [13] = '{0,0,0,1,0,0,1,0,0,1,0,0,1};
  int esd_a [13] = '{1,2,3,1,2,3,1,2,3,1,2,3,1};
  int ezn_a [13] = '{0,0,0,1,0,0,0,0,0,1,0,0,0};
  int esn_a [13] = '{1,2,3,0,1,0,1,2,3,0,1,0,1};
  int ecs_a [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,3};

  seq_detector_param u_dflt (
    .Clock (Clock), .Resetn(Resetn), .En(En), .w(w), .Clear(Clear),
    .z(z_d), .count(cnt_d),
`ifdef SEQ_DET_REG_OUT_EN
    .z_q(zq_d),
`endif
    .state(st_d)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_novl (
    .Clock (Clock), .Resetn(Resetn), .En(En), .w(w), .Clear(Clear),
    .z(z_n), .count(cnt_n),
`ifdef SEQ_DET_REG_OUT_EN
    .z_q(zq_n),
`endif
    .state(st_n)
  );

  seq_detector_param #(.CNT_W(2)) u_sat (
    .Clock (Clock), .Resetn(Resetn), .En(En), .w(w), .Clear(Clear),
    .z(z_s), .count(cnt_s),
`ifdef SEQ_DET_REG_OUT_EN
    .z_q(zq_s),
`endif
    .state(st_s)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called just after a rising edge. Drives one sample, checks z mid-cycle,
  // clocks it in, then checks the resulting state.
  task automatic step(input logic wi, input logic en, input logic clr,
                      input int ezd, input int esd, input int ezn, input int esn);
    w = wi; En = en; Clear = clr;
    #2;
    check("z_dflt", {31'd0, z_d}, ezd);
    check("z_novl", {31'd0, z_n}, ezn);
    @(posedge Clock); #1;
    check("state_dflt", {30'd0, st_d}, esd);
    check("state_novl", {30'd0, st_n}, esn);
`ifdef SEQ_DET_REG_OUT_EN
    check("zq_dflt", {31'd0, zq_d}, ezd);
    check("zq_novl", {31'd0, zq_n}, ezn);
`endif
    En = 1'b0; Clear = 1'b0;
  endtask

  task automatic do_reset();
    w = 1'b1; En = 1'b1; Clear = 1'b0;
    Resetn = 1'b0;
    #2;
    check("rst_state", {30'd0, st_d}, 0);
    check("rst_count", {24'd0, cnt_d}, 0);
    check("rst_z", {31'd0, z_d}, 0);
    En = 1'b0;
    Resetn = 1'b1;
    @(posedge Clock); #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Resetn = 1'b0; En = 1'b0; w = 1'b0; Clear = 1'b0;
    @(posedge Clock); #1;
    do_reset();
    check("rst_count_sat", {30'd0, cnt_s}, 0);

    // Stream 1,1,0,1,1,0,1: overlap matches on bits 4 and 7.
    step(1,1,0, 0,1, 0,1);
    step(1,1,0, 0,2, 0,2);
    step(0,1,0, 0,3, 0,3);
    step(1,1,0, 1,1, 1,0);
    step(1,1,0, 0,2, 0,1);
    step(0,1,0, 0,3, 0,0);
    step(1,1,0, 1,1, 0,1);
    check("t1_count_dflt", {24'd0, cnt_d}, 2);
    check("t1_count_novl", {24'd0, cnt_n}, 1);

    // Fallback: 1,1,1,0,1 keeps state 2 on the third 1.
    do_reset();
    step(1,1,0, 0,1, 0,1);
    step(1,1,0, 0,2, 0,2);
    step(1,1,0, 0,2, 0,2);
    step(0,1,0, 0,3, 0,3);
    step(1,1,0, 1,1, 1,0);
    check("t2_count_dflt", {24'd0, cnt_d}, 1);

    // Enable gaps: the En=0 sample is ignored.
    do_reset();
    step(1,1,0, 0,1, 0,1);
    step(1,1,0, 0,2, 0,2);
    step(0,0,0, 0,2, 0,2);
    step(0,1,0, 0,3, 0,3);
    step(1,1,0, 1,1, 1,0);
    check("t3_count_dflt", {24'd0, cnt_d}, 1);

    // Saturation on the 2-bit counter.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(sat_w[12-i], 1, 0, ezd_a[i], esd_a[i], ezn_a[i], esn_a[i]);
      check("t4_count_sat", {30'd0, cnt_s}, ecs_a[i]);
    end
    check("t4_count_dflt", {24'd0, cnt_d}, 4);
    check("t4_count_novl", {24'd0, cnt_n}, 2);

    // Clear with En=0: counts cleared, state untouched.
    step(0,0,1, 0,1, 0,1);
    check("t5_clr_dflt", {24'd0, cnt_d}, 0);
    check("t5_clr_sat", {30'd0, cnt_s}, 0);
    check("t5_state_sat", {30'd0, st_s}, 1);

    // Clear coincident with a match wins over the increment.
    step(1,1,0, 0,2, 0,2);
    step(0,1,0, 0,3, 0,3);
    step(1,1,1, 1,1, 1,0);
    check("t6_clr_dflt", {24'd0, cnt_d}, 0);
    check("t6_clr_novl", {24'd0, cnt_n}, 0);
    check("t6_clr_sat", {30'd0, cnt_s}, 0);

    // Reset mid-sequence with a nonzero count.
    do_reset();
    step(1,1,0, 0,1, 0,1);
    step(1,1,0, 0,2, 0,2);
    step(0,1,0, 0,3, 0,3);
    step(1,1,0, 1,1, 1,0);
    step(1,1,0, 0,2, 0,1);
    step(0,1,0, 0,3, 0,0);
    check("t7_count_pre", {24'd0, cnt_d}, 1);
    w = 1'b1; En = 1'b1;
    #1;
    Resetn = 1'b0;
    #1;
    check("t7_state_async", {30'd0, st_d}, 0);
    check("t7_count_async", {24'd0, cnt_d}, 0);
    check("t7_z_async", {31'd0, z_d}, 0);
`ifdef SEQ_DET_REG_OUT_EN
    check("t7_zq_async", {31'd0, zq_d}, 0);
`endif
    Resetn = 1'b1;
    En = 1'b0;
    @(posedge Clock); #1;
    step(1,1,0, 0,1, 0,1);
    check("t7_count_post", {24'd0, cnt_d}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
